// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: default operand width and
// controller state encoding.
package mul_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_ctrl_if.sv
// Request/response handshake between the decode/stall logic (master) and the
// sequential multiplier controller (slave).
interface seq_mul_ctrl_if #(
  parameter int N = mul_pkg::XLEN
);

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] product;
  logic           busy;

  modport master (
    output in_valid,
    output op_a,
    output op_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  product,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  op_a,
    input  op_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output product,
    output busy
  );

endinterface

// File: rtl/seq_mul_ctrl_rca.sv
// Parameterized N-bit ripple-carry adder with carry in and carry out.
module RCA #(
  parameter int N = mul_pkg::XLEN
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  // The carry is threaded bit by bit so the chain stays a true ripple structure.
  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_mul_ctrl.sv
// Shift-add sequential multiplier controller: one RCA reused over N iterations.
// Optional completed-product counter enabled by defining SEQ_MUL_PERF_CNT_EN.
module seq_mul_ctrl
  import mul_pkg::*;
#(
  parameter int N = XLEN
) (
  input  logic          clk,
  input  logic          rst,
  seq_mul_ctrl_if.slave bus
`ifdef SEQ_MUL_PERF_CNT_EN
  ,
  output logic [31:0]   perf_ops
`endif
);

  localparam int CW = $clog2(N + 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  acc_hi;
  logic [N-1:0]  mplr;
  logic [N-1:0]  mcand;
  logic [N-1:0]  addend;
  logic [N-1:0]  sum;
  logic          cout;
  logic [CW-1:0] count;
  logic          accept;
  logic          last_iter;
  logic          release_done;

  assign addend = mplr[0] ? mcand : '0;

  RCA #(.N(N)) u_rca (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // IDLE never accepts in the same edge DONE releases, so back-to-back ops
  // always pass through one IDLE cycle.
  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    last_iter     = 1'b0;
    release_done  = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        bus.busy = 1'b1;
        if (count == CW'(N - 1)) begin
          last_iter = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          release_done = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The adder carry lands in the accumulator MSB as the pair shifts right.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi <= '0;
      mplr   <= '0;
      mcand  <= '0;
      count  <= '0;
    end else if (accept) begin
      mcand  <= bus.op_a;
      mplr   <= bus.op_b;
      acc_hi <= '0;
      count  <= '0;
    end else if (state == CALC) begin
      {acc_hi, mplr} <= {cout, sum, mplr[N-1:1]};
      count          <= count + CW'(1);
    end
  end

  assign bus.product = {acc_hi, mplr};

`ifdef SEQ_MUL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)               perf_ops <= '0;
    else if (release_done) perf_ops <= perf_ops + 32'd1;
  end
`endif

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Directed testbench for seq_mul_ctrl at N=8; define SEQ_MUL_PERF_CNT_EN to
// also exercise the completed-product counter.
module tb_seq_mul_ctrl;

  localparam int N = 8;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
`ifdef SEQ_MUL_PERF_CNT_EN
  logic [31:0] perf_ops;
`endif

  seq_mul_ctrl_if #(.N(N)) bus ();

  seq_mul_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef SEQ_MUL_PERF_CNT_EN
    ,
    .perf_ops (perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with out_ready low, wait for the product, then release it.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    p = bus.product;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL por_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL por_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL por_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.product !== 16'h0000) begin fails++; $display("[TB] FAIL por_product: got %h expected 0000", bus.product); end

    bus.op_a     = 8'h12;
    bus.op_b     = 8'h34;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL mid_calc_busy: got %b expected 1", bus.busy); end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.product !== 16'h0000) begin fails++; $display("[TB] FAIL rst_product: got %h expected 0000", bus.product); end
    step();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_stays_idle: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_basic();
    int edges;
    bus.op_a      = 8'h0D;
    bus.op_b      = 8'h0B;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.op_a     = 8'hAA;
    bus.op_b     = 8'h55;
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      step();
      edges++;
    end
    checks++; if (edges != 8) begin fails++; $display("[TB] FAIL basic_latency: got %0d edges expected 8", edges); end
    checks++; if (bus.product !== 16'h008F) begin fails++; $display("[TB] FAIL basic_product: got %h expected 008f", bus.product); end
    repeat (3) step();
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL basic_hold_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.product !== 16'h008F) begin fails++; $display("[TB] FAIL basic_hold_product: got %h expected 008f", bus.product); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL basic_release_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL basic_release_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_carry_corner();
    logic [15:0] p;
    int lat;
    run_op(8'hFF, 8'hFF, p, lat);
    checks++; if (p !== 16'hFE01) begin fails++; $display("[TB] FAIL ff_x_ff: got %h expected fe01", p); end
    checks++; if (lat != 8) begin fails++; $display("[TB] FAIL ff_x_ff_latency: got %0d expected 8", lat); end
    run_op(8'h00, 8'hFF, p, lat);
    checks++; if (p !== 16'h0000) begin fails++; $display("[TB] FAIL zero_x_ff: got %h expected 0000", p); end
    run_op(8'h80, 8'h02, p, lat);
    checks++; if (p !== 16'h0100) begin fails++; $display("[TB] FAIL 80_x_02: got %h expected 0100", p); end
    run_op(8'hFF, 8'h01, p, lat);
    checks++; if (p !== 16'h00FF) begin fails++; $display("[TB] FAIL ff_x_01: got %h expected 00ff", p); end
  endtask

  task automatic test_backpressure();
    int edges;
    bus.op_a      = 8'h05;
    bus.op_b      = 8'h07;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      step();
      edges++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_done_timeout: got %b expected 1", bus.out_valid); end
    bus.op_a     = 8'h03;
    bus.op_b     = 8'h03;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.product !== 16'h0023) begin fails++; $display("[TB] FAIL bp_product_%0d: got %h expected 0023", i, bus.product); end
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("[TB] FAIL bp_in_ready_%0d: got %b expected 0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_out_valid_%0d: got %b expected 1", i, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL bp_idle_after_release: got %b expected 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_not_busy_after_release: got %b expected 0", bus.busy); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_accept_after_idle: got busy %b expected 1", bus.busy); end
    edges = 0;
    while (!bus.out_valid && edges < 40) begin
      step();
      edges++;
    end
    checks++; if (bus.product !== 16'h0009) begin fails++; $display("[TB] FAIL bp_second_product: got %h expected 0009", bus.product); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] expq[$];
    logic [7:0]  a;
    logic [7:0]  b;
    int accepts;
    int results;
    int cycle;
    int last_acc;
    logic acc_now;
    accepts  = 0;
    results  = 0;
    last_acc = 0;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    bus.op_a      = a;
    bus.op_b      = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (cycle = 1; cycle <= 400 && results < 20; cycle++) begin
      acc_now = bus.in_ready & bus.in_valid;
      step();
      if (acc_now) begin
        expq.push_back(16'(a) * 16'(b));
        if (accepts > 0) begin
          checks++; if (cycle - last_acc != 10) begin fails++; $display("[TB] FAIL b2b_spacing_%0d: got %0d cycles expected 10", accepts, cycle - last_acc); end
        end
        last_acc = cycle;
        accepts++;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        bus.op_a = a;
        bus.op_b = b;
        if (accepts == 20) bus.in_valid = 1'b0;
      end
      if (bus.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          fails++; $display("[TB] FAIL b2b_unexpected_product: got %h expected none", bus.product);
        end else begin
          if (bus.product !== expq[0]) begin fails++; $display("[TB] FAIL b2b_product_%0d: got %h expected %h", results, bus.product, expq[0]); end
          void'(expq.pop_front());
        end
        results++;
      end
    end
    checks++; if (results != 20) begin fails++; $display("[TB] FAIL b2b_result_count: got %0d expected 20", results); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
  endtask

`ifdef SEQ_MUL_PERF_CNT_EN
  task automatic test_perf_cnt();
    logic [15:0] p;
    int lat;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (perf_ops !== 32'd0) begin fails++; $display("[TB] FAIL perf_after_rst: got %0d expected 0", perf_ops); end
    run_op(8'h02, 8'h03, p, lat);
    run_op(8'h04, 8'h05, p, lat);
    run_op(8'h06, 8'h07, p, lat);
    checks++; if (perf_ops !== 32'd3) begin fails++; $display("[TB] FAIL perf_three_ops: got %0d expected 3", perf_ops); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (perf_ops !== 32'd0) begin fails++; $display("[TB] FAIL perf_cleared: got %0d expected 0", perf_ops); end
  endtask
`endif

  initial begin
    checks        = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    test_reset();
    test_basic();
    test_carry_corner();
    test_backpressure();
    test_back_to_back();
`ifdef SEQ_MUL_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
